// File: rtl/modport_stack.sv
// Data stack with the top two entries held in registers (s0/s1). Deeper entries
// live in a spill array that is written on PUSH and read combinationally on POP/PICK.
module modport_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] vi,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PICK = 2'b11
  } stack_op_t;

  localparam int MW = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int AW = (MW > 1) ? $clog2(MW) : 1;

  logic [WIDTH-1:0] mem [MW];
  logic [DW-1:0]    depth_r;
  stack_op_t        op_c;

  logic [DW-1:0]    spill_d, fill_d, pick_d;
  logic [AW-1:0]    spill_a, fill_a, pick_a;
  logic [WIDTH:0]   pick_need;
  logic             push_ok, pop_ok, pick_ok;
  logic [WIDTH-1:0] fill_val, pick_val;

  assign op_c  = stack_op_t'(op);
  assign depth = depth_r;
  assign empty = (depth_r == '0);
  assign full  = (depth_r == DW'(DEPTH));

  // Slot k below TOS (k >= 2) lives at mem[depth-1-k]
  assign spill_d = depth_r - DW'(2);
  assign fill_d  = depth_r - DW'(3);
  assign pick_d  = depth_r - DW'(2) - s0[DW-1:0];
  assign spill_a = spill_d[AW-1:0];
  assign fill_a  = fill_d[AW-1:0];
  assign pick_a  = pick_d[AW-1:0];

  // Index compared one bit wider than the data so an all-ones n cannot wrap
  assign pick_need = {1'b0, s0} + (WIDTH+1)'(2);
  assign pick_ok   = (pick_need <= (WIDTH+1)'(depth_r));
  assign push_ok   = !full;
  assign pop_ok    = !empty;

  assign fill_val  = (depth_r >= DW'(3)) ? mem[fill_a] : '0;
  assign pick_val  = (s0 == '0) ? s1 : mem[pick_a];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0      <= '0;
      s1      <= '0;
      depth_r <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (op_c)
        OP_NOP: ;
        OP_PUSH: begin
          if (push_ok) begin
            s0      <= vi;
            s1      <= s0;
            depth_r <= depth_r + DW'(1);
          end else begin
            err <= 1'b1;
          end
        end
        OP_POP: begin
          if (pop_ok) begin
            s0      <= s1;
            s1      <= fill_val;
            depth_r <= depth_r - DW'(1);
          end else begin
            err <= 1'b1;
          end
        end
        OP_PICK: begin
          if (pick_ok) s0 <= pick_val;
          else         err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage holds data only; no reset needed since slots beyond depth are never read
  always_ff @(posedge clk) begin
    if (op_c == OP_PUSH && push_ok && depth_r >= DW'(2))
      mem[spill_a] <= s1;
  end

endmodule

// File: tb/tb_modport_stack.sv
// Directed bench for modport_stack at DEPTH=4, with a small array model for
// the alternating PUSH/POP sequence.
module tb_modport_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] PICK = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       op = NOP;
  logic [WIDTH-1:0] vi = '0;
  logic [WIDTH-1:0] s0, s1;
  logic [DW-1:0]    depth;
  logic             empty, full, err;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mstk [DEPTH];
  int               mdepth;

  modport_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op),
    .vi    (vi),
    .s0    (s0),
    .s1    (s1),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] v);
    op = o;
    vi = v;
    @(posedge clk);
    #1;
    op = NOP;
  endtask

  task automatic chk_state(input string tag, input logic [WIDTH-1:0] e0,
                           input logic [WIDTH-1:0] e1, input int ed, input logic ee);
    chk({tag, ".s0"}, 64'(s0), 64'(e0));
    chk({tag, ".s1"}, 64'(s1), 64'(e1));
    chk({tag, ".depth"}, 64'(depth), 64'(ed));
    chk({tag, ".err"}, 64'(err), 64'(ee));
  endtask

  initial begin
    // 1. reset then NOP
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s0", 64'(s0), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full", 64'(full), 64'd0);
    rst_n = 1'b1;
    do_op(NOP, 32'h0);
    chk_state("nop", 32'd0, 32'd0, 0, 1'b0);
    chk("nop.empty", 64'(empty), 64'd1);

    // 2. push three, pop three
    do_op(PUSH, 32'd11);
    do_op(PUSH, 32'd22);
    do_op(PUSH, 32'd33);
    chk_state("push3", 32'd33, 32'd22, 3, 1'b0);
    do_op(POP, 32'h0);
    chk_state("pop1", 32'd22, 32'd11, 2, 1'b0);
    do_op(POP, 32'h0);
    chk_state("pop2", 32'd11, 32'd0, 1, 1'b0);
    do_op(POP, 32'h0);
    chk_state("pop3", 32'd0, 32'd0, 0, 1'b0);
    chk("pop3.empty", 64'(empty), 64'd1);

    // 3. overflow and underflow
    do_op(PUSH, 32'd1);
    do_op(PUSH, 32'd2);
    do_op(PUSH, 32'd3);
    do_op(PUSH, 32'd4);
    chk("fill.full", 64'(full), 64'd1);
    chk_state("fill", 32'd4, 32'd3, 4, 1'b0);
    do_op(PUSH, 32'd5);
    chk_state("ovf", 32'd4, 32'd3, 4, 1'b1);
    do_op(NOP, 32'h0);
    chk("ovf.errclr", 64'(err), 64'd0);
    do_op(POP, 32'h0);
    chk_state("drain1", 32'd3, 32'd2, 3, 1'b0);
    do_op(POP, 32'h0);
    chk_state("drain2", 32'd2, 32'd1, 2, 1'b0);
    do_op(POP, 32'h0);
    chk_state("drain3", 32'd1, 32'd0, 1, 1'b0);
    do_op(POP, 32'h0);
    chk_state("drain4", 32'd0, 32'd0, 0, 1'b0);
    do_op(POP, 32'h0);
    chk_state("udf", 32'd0, 32'd0, 0, 1'b1);
    do_op(POP, 32'h0);
    chk("udf2.err", 64'(err), 64'd1);
    do_op(NOP, 32'h0);
    chk("udf.errclr", 64'(err), 64'd0);

    // 4. PICK
    do_op(PUSH, 32'd10);
    do_op(PUSH, 32'd20);
    do_op(PUSH, 32'd30);
    do_op(PUSH, 32'd1);
    do_op(PICK, 32'hDEAD);
    chk_state("pick1", 32'd20, 32'd30, 4, 1'b0);
    do_op(POP, 32'h0);
    chk_state("pick.pop", 32'd30, 32'd20, 3, 1'b0);
    do_op(PUSH, 32'd5);
    do_op(PICK, 32'h0);
    chk_state("pick5", 32'd5, 32'd30, 4, 1'b1);
    do_op(POP, 32'h0);
    do_op(PUSH, 32'd2);
    do_op(PICK, 32'h0);
    chk_state("pick2", 32'd10, 32'd30, 4, 1'b0);
    do_op(POP, 32'h0);
    do_op(PUSH, 32'd0);
    do_op(PICK, 32'h0);
    chk_state("pick0", 32'd30, 32'd30, 4, 1'b0);
    do_op(POP, 32'h0);
    do_op(PUSH, 32'hFFFF_FFFF);
    do_op(PICK, 32'h0);
    chk_state("pickhuge", 32'hFFFF_FFFF, 32'd30, 4, 1'b1);
    do_op(POP, 32'h0);
    do_op(POP, 32'h0);
    do_op(PUSH, 32'd1);
    do_op(PICK, 32'h0);
    chk_state("pick.edge", 32'd10, 32'd20, 3, 1'b0);
    do_op(POP, 32'h0);
    do_op(POP, 32'h0);
    do_op(POP, 32'h0);
    chk_state("pick.clear", 32'd0, 32'd0, 0, 1'b0);

    // 5. alternating PUSH/POP against the model, crossing depths 2 and 3
    mdepth = 0;
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] v;
      logic [1:0]       o;
      logic [WIDTH-1:0] e0, e1;
      v = $urandom;
      if (i < 2)              o = PUSH;
      else if (i >= 16 && i < 20) o = PUSH;
      else                    o = (i % 2 == 0) ? PUSH : POP;
      do_op(o, v);
      if (o == PUSH && mdepth < DEPTH) begin
        mstk[mdepth] = v;
        mdepth++;
      end else if (o == POP && mdepth > 0) begin
        mdepth--;
      end
      e0 = (mdepth > 0) ? mstk[mdepth-1] : '0;
      e1 = (mdepth > 1) ? mstk[mdepth-2] : '0;
      chk($sformatf("alt%0d.s0", i), 64'(s0), 64'(e0));
      chk($sformatf("alt%0d.s1", i), 64'(s1), 64'(e1));
      chk($sformatf("alt%0d.depth", i), 64'(depth), 64'(mdepth));
    end
    while (mdepth > 0) begin
      do_op(POP, 32'h0);
      mdepth--;
    end
    chk("alt.drained", 64'(depth), 64'd0);

    // 6. async reset in the middle of a PUSH
    do_op(PUSH, 32'd7);
    do_op(PUSH, 32'd8);
    do_op(PUSH, 32'd9);
    chk_state("pre.rst", 32'd9, 32'd8, 3, 1'b0);
    op = PUSH;
    vi = 32'd99;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.s0", 64'(s0), 64'd0);
    chk("arst.s1", 64'(s1), 64'd0);
    chk("arst.depth", 64'(depth), 64'd0);
    chk("arst.empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1;
    chk("arst.hold", 64'(depth), 64'd0);
    op = NOP;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(PUSH, 32'd42);
    chk_state("post.rst", 32'd42, 32'd0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
